// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one ser_tx pad between NREQ byte producers, with an 8N1 serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits (8E1).
`timescale 1ns/1ps

module uart_tx_arbiter_chk #(
  parameter int NREQ = 2
) (
  input logic            clk,
  input logic            reset,
  input logic [NREQ-1:0] req_valid,
  input logic [NREQ-1:0] req_ready,
  input logic [2:0]      grant_id,
  input logic            busy,
  input logic            ser_tx
);

  a_ready_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0(req_ready));

  a_ready_needs_valid: assert property (@(posedge clk) disable iff (reset)
    (req_ready & ~req_valid) == {NREQ{1'b0}});

  a_ready_only_idle: assert property (@(posedge clk) disable iff (reset)
    (req_ready != {NREQ{1'b0}}) |-> !busy);

  a_idle_line_high: assert property (@(posedge clk) disable iff (reset)
    !busy |-> ser_tx);

  a_grant_in_range: assert property (@(posedge clk) disable iff (reset)
    {1'b0, grant_id} < 4'(NREQ));

endmodule

module uart_tx_arbiter #(
  parameter int NREQ  = 2,
  parameter int DIV_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DIV_W-1:0]  div,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [2:0]        grant_id,
  output logic              busy,
  output logic              ser_tx
);

  localparam logic [DIV_W-1:0] CNT_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] CNT_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  function automatic logic even_parity(input logic [7:0] data_byte);
    return ^data_byte;
  endfunction
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd4
  } state_e;
`endif

  state_e           state_r;
  logic [7:0]       byte_r;
  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] cnt_r;
  logic [2:0]       bit_r;
  logic [2:0]       rr_r;
  logic [2:0]       grant_r;
  logic             busy_r;
  logic             tx_r;

  logic [NREQ-1:0]  rot_s;
  logic [2:0]       off_s;
  logic [3:0]       sum_s;
  logic [2:0]       pick_s;
  logic             hit_s;
  logic             accept_s;
  logic [NREQ-1:0]  ready_s;
  logic [7:0]       pick_byte_s;
  logic [2:0]       rr_next_s;
  logic             bit_end_s;

  // Round-robin search: rotate valids so the pointer sits at bit 0, take the lowest set bit.
  always_comb begin
    rot_s = NREQ'({req_valid, req_valid} >> rr_r);
    off_s = 3'd0;
    hit_s = 1'b0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      off_s = rot_s[j] ? 3'(j) : off_s;
      hit_s = hit_s | rot_s[j];
    end
    sum_s  = {1'b0, rr_r} + {1'b0, off_s};
    pick_s = (sum_s >= 4'(NREQ)) ? 3'(sum_s - 4'(NREQ)) : sum_s[2:0];
  end

  // Grant decode and byte select; ready is suppressed while reset is held so no byte is lost.
  always_comb begin
    accept_s    = (state_r == ST_IDLE) && hit_s && !reset;
    ready_s     = {NREQ{1'b0}};
    pick_byte_s = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      ready_s[i]  = accept_s && (pick_s == 3'(i));
      pick_byte_s = (pick_s == 3'(i)) ? req_data[8*i +: 8] : pick_byte_s;
    end
    rr_next_s = (pick_s == 3'(NREQ - 1)) ? 3'd0 : pick_s + 3'd1;
    bit_end_s = (cnt_r == div_r);
  end

  // Frame sequencer: every state lasts div_r+1 cycles, outputs are registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      byte_r  <= 8'h00;
      div_r   <= CNT_ZERO;
      cnt_r   <= CNT_ZERO;
      bit_r   <= 3'd0;
      rr_r    <= 3'd0;
      grant_r <= 3'd0;
      busy_r  <= 1'b0;
      tx_r    <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r <= ST_START;
            byte_r  <= pick_byte_s;
            div_r   <= div;
            cnt_r   <= CNT_ZERO;
            bit_r   <= 3'd0;
            grant_r <= pick_s;
            rr_r    <= rr_next_s;
            busy_r  <= 1'b1;
            tx_r    <= 1'b0;
          end else begin
            busy_r  <= 1'b0;
            tx_r    <= 1'b1;
          end
        end
        ST_START: begin
          if (bit_end_s) begin
            state_r <= ST_DATA;
            cnt_r   <= CNT_ZERO;
            tx_r    <= byte_r[0];
          end else begin
            cnt_r   <= cnt_r + CNT_ONE;
          end
        end
        ST_DATA: begin
          if (bit_end_s) begin
            cnt_r <= CNT_ZERO;
            if (bit_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_r <= ST_PARITY;
              tx_r    <= even_parity(byte_r);
`else
              state_r <= ST_STOP;
              tx_r    <= 1'b1;
`endif
            end else begin
              bit_r <= bit_r + 3'd1;
              tx_r  <= byte_r[bit_r + 3'd1];
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_end_s) begin
            state_r <= ST_STOP;
            cnt_r   <= CNT_ZERO;
            tx_r    <= 1'b1;
          end else begin
            cnt_r   <= cnt_r + CNT_ONE;
          end
        end
`endif
        ST_STOP: begin
          if (bit_end_s) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            busy_r  <= 1'b0;
            tx_r    <= 1'b1;
          end else begin
            cnt_r   <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= CNT_ZERO;
          busy_r  <= 1'b0;
          tx_r    <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = ready_s;
  assign grant_id  = grant_r;
  assign busy      = busy_r;
  assign ser_tx    = tx_r;

  uart_tx_arbiter_chk #(.NREQ(NREQ)) u_chk (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (ready_s),
    .grant_id  (grant_r),
    .busy      (busy_r),
    .ser_tx    (tx_r)
  );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against a frame-level reference model.
`timescale 1ns/1ps

module tb_uart_tx_arbiter;
  localparam int NREQ  = 2;
  localparam int DIV_W = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
  localparam logic [15:0] T1_BITS = 16'b0000_0101_0100_1010;
  localparam logic [15:0] T5_BITS = 16'b0000_0110_0000_1110;
`else
  localparam int FRAME_BITS = 10;
  localparam logic [15:0] T1_BITS = 16'b0000_0011_0100_1010;
  localparam logic [15:0] T5_BITS = 16'b0000_0010_0000_1110;
`endif

  logic              clk;
  logic              reset;
  logic [DIV_W-1:0]  div;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic [2:0]        grant_id;
  logic              busy;
  logic              ser_tx;

  uart_tx_arbiter #(.NREQ(NREQ), .DIV_W(DIV_W)) dut (
    .clk(clk), .reset(reset), .div(div), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .grant_id(grant_id), .busy(busy), .ser_tx(ser_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;
  logic [1:0] exp_q[$];
  int m_rr;
  int m_gid;
  logic [7:0] src_q[NREQ][$];
  logic [NREQ-1:0] en;
  logic tx_trace[$];
  int obs_grants[$];
  int busy_runs[$];
  int cur_run;
  logic s_tx;
  logic s_busy;
  logic [NREQ-1:0] s_ready;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int arb_pick(input logic [NREQ-1:0] v, input int rr);
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (rr + k) % NREQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic push_frame(input logic [7:0] b, input int d);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    bits.push_back(^b);
`endif
    bits.push_back(1'b1);
    foreach (bits[k]) repeat (d + 1) exp_q.push_back({1'b1, bits[k]});
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = en[i] && (src_q[i].size() > 0);
      req_data[8*i +: 8] = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
    end
  endtask

  // One clock cycle: check outputs against the model, then advance the model at the edge.
  task automatic tick();
    logic [NREQ-1:0] exp_ready;
    logic exp_tx;
    logic exp_busy;
    int pick;
    #1;
    pick = arb_pick(req_valid, m_rr);
    exp_ready = '0;
    if (!reset && exp_q.size() == 0 && pick >= 0) exp_ready[pick] = 1'b1;
    if (exp_q.size() == 0) begin
      exp_tx = 1'b1;
      exp_busy = 1'b0;
    end else begin
      exp_tx = exp_q[0][0];
      exp_busy = exp_q[0][1];
    end
    check_val("ser_tx", ser_tx, exp_tx);
    check_val("busy", busy, exp_busy);
    check_val("req_ready", req_ready, exp_ready);
    check_val("grant_id", grant_id, m_gid);
    s_tx = ser_tx;
    s_busy = busy;
    s_ready = req_ready;
    tx_trace.push_back(ser_tx);
    for (int i = 0; i < NREQ; i++) if (req_ready[i]) obs_grants.push_back(i);
    if (busy === 1'b1) cur_run++;
    else begin
      if (cur_run > 0) busy_runs.push_back(cur_run);
      cur_run = 0;
    end
    @(posedge clk);
    if (reset) begin
      exp_q.delete();
      m_rr = 0;
      m_gid = 0;
    end else if (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
    end else if (pick >= 0) begin
      push_frame(src_q[pick][0], int'(div));
      void'(src_q[pick].pop_front());
      m_gid = pick;
      m_rr = (pick + 1) % NREQ;
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      drive_inputs();
      tick();
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    run(n);
    reset = 1'b0;
  endtask

  function automatic bit srcs_empty();
    for (int i = 0; i < NREQ; i++) if (src_q[i].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input int limit, input string tag);
    int n = 0;
    while (!(exp_q.size() == 0 && srcs_empty()) && n < limit) begin
      drive_inputs();
      tick();
      n++;
    end
    check_val({tag, "_in_time"}, (n < limit), 1);
  endtask

  task automatic wait_busy(input int limit, input string tag);
    int n = 0;
    s_busy = 1'b0;
    while (!s_busy && n < limit) begin
      drive_inputs();
      tick();
      n++;
    end
    check_val({tag, "_busy_seen"}, s_busy, 1);
  endtask

  task automatic check_trace(input string tag, input logic [15:0] bits, input int nbits,
                             input int per, input int from);
    int j = -1;
    for (int k = from; k < tx_trace.size(); k++) begin
      if (tx_trace[k] == 1'b0) begin
        j = k;
        break;
      end
    end
    check_val({tag, "_start_found"}, (j >= 0), 1);
    if (j >= 0) begin
      for (int b = 0; b < nbits; b++) begin
        for (int c = 0; c < per; c++) begin
          int idx;
          idx = j + b * per + c;
          if (idx < tx_trace.size()) check_val(tag, tx_trace[idx], bits[b]);
          else check_val({tag, "_length"}, (idx < tx_trace.size()), 1);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int mark;
    int g0;
    int idle_bad;
    int pushed;
    total = 0; bad = 0; m_rr = 0; m_gid = 0; cur_run = 0;
    reset = 1'b1; div = '0; req_valid = '0; req_data = '0; en = '1;
    @(negedge clk);

    // Reset state
    do_reset(2);
    check_val("rst_ser_tx", ser_tx, 1);
    check_val("rst_busy", busy, 0);

    // 1: div=3, 0xA5 from req0, single-cycle ready pulse
    div = 16'd3;
    mark = tx_trace.size();
    g0 = obs_grants.size();
    src_q[0].push_back(8'hA5);
    wait_idle(200, "t1");
    run(4);
    check_trace("t1_bits", T1_BITS, FRAME_BITS, 4, mark);
    check_val("t1_ready_pulses", obs_grants.size() - g0, 1);

    // 2: both requesters valid continuously, div=0 -> alternating grants
    do_reset(2);
    div = 16'd0;
    g0 = obs_grants.size();
    for (int k = 0; k < 4; k++) begin
      src_q[0].push_back(8'h10 + 8'(k));
      src_q[1].push_back(8'h20 + 8'(k));
    end
    wait_idle(500, "t2");
    check_val("t2_grant_count", obs_grants.size() - g0, 8);
    for (int k = 0; k < 8; k++)
      if (g0 + k < obs_grants.size()) check_val("t2_grant_order", obs_grants[g0 + k], k % 2);

    // 3: div change mid-frame only affects the next frame
    div = 16'd1;
    busy_runs.delete();
    cur_run = 0;
    src_q[0].push_back(8'h3C);
    src_q[0].push_back(8'hC3);
    wait_busy(50, "t3");
    run(3);
    div = 16'd7;
    wait_idle(500, "t3");
    run(2);
    check_val("t3_run_count", busy_runs.size(), 2);
    if (busy_runs.size() >= 2) begin
      check_val("t3_frame1_len", busy_runs[0], 2 * FRAME_BITS);
      check_val("t3_frame2_len", busy_runs[1], 8 * FRAME_BITS);
    end

    // 4: reset during data bit 3, then req0 regains priority
    do_reset(2);
    div = 16'd2;
    src_q[0].push_back(8'h5A);
    wait_busy(50, "t4");
    run(12);
    src_q[1].push_back(8'h99);
    reset = 1'b1;
    run(1);
    run(1);
    check_val("t4_rst_tx", s_tx, 1);
    check_val("t4_rst_busy", s_busy, 0);
    check_val("t4_rst_ready", s_ready, 0);
    src_q[0].push_back(8'h66);
    reset = 1'b0;
    g0 = obs_grants.size();
    wait_idle(300, "t4");
    check_val("t4_grant_count", obs_grants.size() - g0, 2);
    if (obs_grants.size() >= g0 + 2) begin
      check_val("t4_first_grant", obs_grants[g0], 0);
      check_val("t4_second_grant", obs_grants[g0 + 1], 1);
    end

    // 5: byte 0x07 at div=0
    div = 16'd0;
    mark = tx_trace.size();
    src_q[0].push_back(8'h07);
    wait_idle(100, "t5");
    run(2);
    check_trace("t5_bits", T5_BITS, FRAME_BITS, 1, mark);

    // 6: 1000 quiet cycles after reset
    do_reset(2);
    idle_bad = 0;
    repeat (1000) begin
      drive_inputs();
      tick();
      if (s_tx !== 1'b1 || s_busy !== 1'b0) idle_bad++;
    end
    check_val("t6_idle_violations", idle_bad, 0);

    // Randomized traffic with dropping valids and changing div
    do_reset(2);
    g0 = obs_grants.size();
    pushed = 0;
    repeat (3000) begin
      for (int i = 0; i < NREQ; i++) begin
        if (src_q[i].size() < 4 && $urandom_range(0, 5) == 0) begin
          src_q[i].push_back(8'($urandom_range(0, 255)));
          pushed++;
        end
        en[i] = ($urandom_range(0, 9) != 0);
      end
      if ($urandom_range(0, 29) == 0) div = 16'($urandom_range(0, 3));
      drive_inputs();
      tick();
    end
    en = '1;
    wait_idle(2000, "rand");
    run(2);
    check_val("rand_bytes_sent", obs_grants.size() - g0, pushed);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
